// File: rtl/io_bank_pkg.sv
// Shared constants and helpers for the IO port bank: register offsets,
// port stride, tick timing and the output-latch update rule.
package io_bank_pkg;

  typedef enum logic [1:0] {
    OFS_DATA = 2'd0,
    OFS_SET  = 2'd1,
    OFS_CLR  = 2'd2,
    OFS_CHG  = 2'd3
  } reg_sel_e;

  localparam int         PORT_STRIDE  = 4;
  localparam logic [7:0] CHG_MASK     = 8'hFF;
  localparam int         WR_TICK_EDGE = 2;
  localparam logic [1:0] ARM_EDGES    = 2'd3;

  // New output-latch value for a write landing on register sel.
  function automatic logic [7:0] next_out(input reg_sel_e sel,
                                          input logic [7:0] cur,
                                          input logic [7:0] wd);
    logic [7:0] res;
    res = cur;
    case (sel)
      OFS_DATA: res = wd;
      OFS_SET:  res = cur | wd;
      OFS_CLR:  res = cur & ~wd;
      default:  res = cur;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/iorq_tick_gen.sv
// Turns the raw CPU IO strobes into single-edge read/write ticks, shared by
// every port of the bank.
module iorq_tick_gen
  import io_bank_pkg::*;
(
  input  logic phi,
  input  logic reset,
  input  logic iorq_n,
  input  logic rd_n,
  input  logic wr_n,
  output logic wr_tick,
  output logic rd_tick
);

  logic       wr_act;
  logic       rd_act;
  logic [1:0] wr_cnt_q;
  logic       rd_cnt_q;
  logic       wr_armed_q;
  logic       rd_armed_q;

  assign wr_act = ~iorq_n & ~wr_n;
  assign rd_act = ~iorq_n & ~rd_n;

  // Disarmed after reset so a bus cycle cut by reset never completes later.
  assign wr_tick = wr_act & wr_armed_q & (wr_cnt_q == 2'(WR_TICK_EDGE - 1));
  assign rd_tick = rd_act & rd_armed_q & ~rd_cnt_q;

  always_ff @(posedge phi) begin
    if (reset) begin
      wr_cnt_q   <= 2'd0;
      rd_cnt_q   <= 1'b0;
      wr_armed_q <= 1'b0;
      rd_armed_q <= 1'b0;
    end else begin
      wr_armed_q <= wr_armed_q | ~wr_act;
      rd_armed_q <= rd_armed_q | ~rd_act;

      if (!wr_act) begin
        wr_cnt_q <= 2'd0;
      end else if (wr_armed_q && (wr_cnt_q != 2'(WR_TICK_EDGE))) begin
        wr_cnt_q <= wr_cnt_q + 2'd1;
      end

      if (!rd_act) begin
        rd_cnt_q <= 1'b0;
      end else if (rd_armed_q) begin
        rd_cnt_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_port_bank.sv
// Bank of NPORTS 8-bit IO ports: output latches with set/clear access,
// synchronised inputs, sticky change flags and a shared active-low interrupt.
module io_port_bank
  import io_bank_pkg::*;
#(
  parameter logic [7:0] BASE      = 8'hF0,
  parameter int         NPORTS    = 2,
  parameter logic [7:0] OUT_RESET = 8'h00
) (
  input  logic                  phi,
  input  logic                  reset,
  input  logic                  iorq_n,
  input  logic                  rd_n,
  input  logic                  wr_n,
  input  logic [7:0]            a,
  input  logic [7:0]            d_in,
  output logic [7:0]            d_out,
  output logic                  d_oe,
  input  logic [8*NPORTS-1:0]   pin_in,
  output logic [8*NPORTS-1:0]   pin_out,
  output logic                  irq_n
);

  localparam logic [8:0] SPAN_LAST = {1'b0, BASE} + 9'(PORT_STRIDE * NPORTS - 1);

  logic              wr_tick;
  logic              rd_tick;
  logic              hit;
  logic              rd_act;
  logic [2:0]        port_idx;
  reg_sel_e          reg_sel;
  logic [7:0]        live_rd;
  logic              any_flag;
  logic [1:0]        arm_cnt_q;
  logic              detect_en;
  logic              rd_hold_q;
  logic [7:0]        rd_snap_q;
  logic [NPORTS-1:0] wr_port;

  logic [7:0] out_q   [NPORTS];
  logic [7:0] flags_q [NPORTS];
  logic [7:0] sync1_q [NPORTS];
  logic [7:0] sync2_q [NPORTS];
  logic [7:0] prev_q  [NPORTS];
  logic [7:0] chg_w1c [NPORTS];

  iorq_tick_gen u_tick (
    .phi     (phi),
    .reset   (reset),
    .iorq_n  (iorq_n),
    .rd_n    (rd_n),
    .wr_n    (wr_n),
    .wr_tick (wr_tick),
    .rd_tick (rd_tick)
  );

  // BASE is aligned to the bank size, so the port index falls out of a[4:2].
  assign hit      = ({1'b0, a} >= {1'b0, BASE}) && ({1'b0, a} <= SPAN_LAST);
  assign port_idx = a[4:2] - BASE[4:2];
  assign reg_sel  = reg_sel_e'(a[1:0]);
  assign rd_act   = ~iorq_n & ~rd_n;
  assign d_oe     = rd_act & hit;
  assign detect_en = (arm_cnt_q == ARM_EDGES);

  always_comb begin
    wr_port = '0;
    for (int k = 0; k < NPORTS; k++) begin
      wr_port[k] = wr_tick & hit & (port_idx == 3'(k));
    end
  end

  always_comb begin
    for (int k = 0; k < NPORTS; k++) begin
      chg_w1c[k] = (wr_port[k] && (reg_sel == OFS_CHG)) ? d_in : 8'h00;
    end
  end

  always_comb begin
    live_rd  = 8'h00;
    any_flag = 1'b0;
    for (int k = 0; k < NPORTS; k++) begin
      any_flag = any_flag | (|(flags_q[k] & CHG_MASK));
      if (hit && (port_idx == 3'(k))) begin
        case (reg_sel)
          OFS_DATA: live_rd = sync2_q[k];
          OFS_SET:  live_rd = out_q[k];
          OFS_CLR:  live_rd = CHG_MASK;
          default:  live_rd = flags_q[k];
        endcase
      end
    end
  end

  // Read data is frozen at the read tick so the CPU sees one coherent value
  // even if pins or flags move during the rest of the strobe.
  assign d_out = rd_hold_q ? rd_snap_q : live_rd;

  always_ff @(posedge phi) begin
    if (reset) begin
      for (int k = 0; k < NPORTS; k++) begin
        out_q[k]   <= OUT_RESET;
        flags_q[k] <= 8'h00;
        sync1_q[k] <= 8'h00;
        sync2_q[k] <= 8'h00;
        prev_q[k]  <= 8'h00;
      end
    end else begin
      for (int k = 0; k < NPORTS; k++) begin
        sync1_q[k] <= pin_in[8*k +: 8];
        sync2_q[k] <= sync1_q[k];
        prev_q[k]  <= sync2_q[k];
        if (wr_port[k]) begin
          out_q[k] <= next_out(reg_sel, out_q[k], d_in);
        end
        // A fresh change beats a same-edge W1C of that bit.
        flags_q[k] <= (flags_q[k] & ~chg_w1c[k]) |
                      (detect_en ? (sync2_q[k] ^ prev_q[k]) : 8'h00);
      end
    end
  end

  always_ff @(posedge phi) begin
    if (reset) begin
      arm_cnt_q <= 2'd0;
      irq_n     <= 1'b1;
      rd_hold_q <= 1'b0;
      rd_snap_q <= 8'h00;
    end else begin
      if (arm_cnt_q != ARM_EDGES) begin
        arm_cnt_q <= arm_cnt_q + 2'd1;
      end
      irq_n     <= ~any_flag;
      rd_hold_q <= rd_hold_q ? rd_act : (rd_tick & hit);
      if (rd_tick && hit) begin
        rd_snap_q <= live_rd;
      end
    end
  end

  for (genvar k = 0; k < NPORTS; k++) begin : g_pin
    assign pin_out[8*k +: 8] = out_q[k];
  end

endmodule

// File: tb/tb_io_port_bank.sv
// Scoreboard bench for io_port_bank: stimulus queues expected responses,
// a monitor pops them as the DUT presents read data or state.
module tb_io_port_bank;

  logic        phi;
  logic        reset;
  logic        iorq_n;
  logic        rd_n;
  logic        wr_n;
  logic [7:0]  a;
  logic [7:0]  d_in;
  logic [7:0]  d_out;
  logic        d_oe;
  logic [15:0] pin_in;
  logic [15:0] pin_out;
  logic        irq_n;

  typedef enum {CK_DOUT, CK_DOE, CK_PIN, CK_IRQN} ck_kind_e;
  typedef struct {
    ck_kind_e    kind;
    string       name;
    logic [15:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int checks = 0;
  int errors = 0;

  io_port_bank #(
    .BASE      (8'hF0),
    .NPORTS    (2),
    .OUT_RESET (8'h00)
  ) dut (
    .phi     (phi),
    .reset   (reset),
    .iorq_n  (iorq_n),
    .rd_n    (rd_n),
    .wr_n    (wr_n),
    .a       (a),
    .d_in    (d_in),
    .d_out   (d_out),
    .d_oe    (d_oe),
    .pin_in  (pin_in),
    .pin_out (pin_out),
    .irq_n   (irq_n)
  );

  initial phi = 1'b0;
  always #5 phi = ~phi;

  task automatic step();
    @(negedge phi);
  endtask

  task automatic applyStimulus(input logic iorq, input logic rd, input logic wr,
                               input logic [7:0] addr, input logic [7:0] data);
    iorq_n = iorq;
    rd_n   = rd;
    wr_n   = wr;
    a      = addr;
    d_in   = data;
  endtask

  task automatic bus_idle();
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h00, 8'h00);
  endtask

  task automatic checkOutput(input ck_kind_e kind, input string name,
                             input logic [15:0] exp);
    sb_item_t it;
    it.kind = kind;
    it.name = name;
    it.exp  = exp;
    sb_q.push_back(it);
  endtask

  task automatic checkNow(input string name, input logic [15:0] act,
                          input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic io_write(input logic [7:0] addr, input logic [7:0] data,
                          input int edges);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, addr, data);
    repeat (edges) step();
    bus_idle();
  endtask

  task automatic io_read(input logic [7:0] addr, input logic [7:0] exp,
                         input string name);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1, addr, 8'h00);
    checkOutput(CK_DOUT, name, {8'h00, exp});
    checkOutput(CK_DOE, {name, "_oe"}, 16'h0001);
    step();
    step();
    bus_idle();
  endtask

  // Monitor: state items compare immediately, read items wait for d_oe to rise.
  initial begin : monitor
    logic        prev_oe;
    logic        stall;
    logic [15:0] act;
    sb_item_t    it;
    prev_oe = 1'b0;
    forever begin
      @(negedge phi);
      #1;
      stall = 1'b0;
      while (!stall && (sb_q.size() > 0)) begin
        it = sb_q[0];
        if ((it.kind == CK_DOUT) && !(d_oe && !prev_oe)) begin
          stall = 1'b1;
        end else begin
          void'(sb_q.pop_front());
          case (it.kind)
            CK_DOUT: act = {8'h00, d_out};
            CK_DOE:  act = {15'h0000, d_oe};
            CK_PIN:  act = pin_out;
            default: act = {15'h0000, irq_n};
          endcase
          checks++;
          if (act !== it.exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", it.name, act, it.exp);
          end
        end
      end
      prev_oe = d_oe;
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    sb_item_t it;
    reset  = 1'b1;
    pin_in = 16'h0000;
    bus_idle();
    repeat (3) step();
    reset = 1'b0;
    checkNow("now_reset_pin_out", pin_out, 16'h0000);
    checkNow("now_reset_irq_n", {15'h0000, irq_n}, 16'h0001);
    checkNow("now_reset_d_oe", {15'h0000, d_oe}, 16'h0000);
    checkOutput(CK_PIN, "reset_pin_out", 16'h0000);
    checkOutput(CK_IRQN, "reset_irq_n", 16'h0001);
    checkOutput(CK_DOE, "reset_d_oe", 16'h0000);
    repeat (2) step();

    // DATA write lands on the 2nd edge only; changed d_in on the 3rd edge must be ignored
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hF0, 8'hA5);
    checkOutput(CK_PIN, "wr_before", 16'h0000);
    step();
    checkOutput(CK_PIN, "wr_edge1", 16'h0000);
    step();
    checkOutput(CK_PIN, "wr_edge2", 16'h00A5);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hF0, 8'h5A);
    step();
    bus_idle();
    checkNow("now_wr_once", pin_out, 16'h00A5);
    checkOutput(CK_PIN, "wr_once", 16'h00A5);

    io_write(8'hF1, 8'h0A, 3);
    checkNow("now_set_bits", pin_out, 16'h00AF);
    checkOutput(CK_PIN, "set_bits", 16'h00AF);
    io_write(8'hF2, 8'h81, 3);
    checkNow("now_clr_bits", pin_out, 16'h002E);
    checkOutput(CK_PIN, "clr_bits", 16'h002E);
    io_read(8'hF1, 8'h2E, "rd_set");
    io_read(8'hF2, 8'hFF, "rd_mask");
    io_read(8'hF0, 8'h00, "rd_data");
    io_read(8'hF3, 8'h00, "rd_chg0");

    // Port 1 pin change: flag after 3 edges, irq one edge later
    step();
    pin_in = 16'h0400;
    step();
    step();
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hF7, 8'h00);
    checkOutput(CK_DOUT, "chg_edge2", 16'h0000);
    checkOutput(CK_IRQN, "irq_edge2", 16'h0001);
    step();
    bus_idle();
    checkOutput(CK_IRQN, "irq_edge3", 16'h0001);
    step();
    checkOutput(CK_IRQN, "irq_edge4", 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hF7, 8'h00);
    checkOutput(CK_DOUT, "chg_set", 16'h0004);
    step();
    step();
    bus_idle();
    io_write(8'hF7, 8'h04, 3);
    checkOutput(CK_IRQN, "irq_w1c", 16'h0001);
    io_read(8'hF7, 8'h00, "chg_w1c");

    // Pin toggles on the same edge the W1C of that bit ticks
    step();
    pin_in = 16'h0000;
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hF7, 8'h04);
    step();
    step();
    bus_idle();
    step();
    checkOutput(CK_IRQN, "irq_set_wins", 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hF7, 8'h00);
    checkOutput(CK_DOUT, "set_wins", 16'h0004);
    step();
    step();
    bus_idle();
    io_write(8'hF7, 8'h04, 3);
    checkOutput(CK_IRQN, "irq_clear2", 16'h0001);

    // Port 0 inputs and change flags
    step();
    pin_in = 16'h003C;
    repeat (4) step();
    io_read(8'hF0, 8'h3C, "rd_pins0");
    io_read(8'hF3, 8'h3C, "rd_chg_p0");
    checkOutput(CK_IRQN, "irq_p0", 16'h0000);
    io_write(8'hF3, 8'h3C, 3);
    checkOutput(CK_IRQN, "irq_p0_clear", 16'h0001);

    // Out-of-range addresses and a too-short write strobe
    step();
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hF8, 8'h00);
    checkOutput(CK_DOE, "doe_f8", 16'h0000);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hEF, 8'h00);
    checkOutput(CK_DOE, "doe_ef", 16'h0000);
    step();
    bus_idle();
    io_write(8'hF8, 8'hFF, 3);
    checkOutput(CK_PIN, "no_write_f8", 16'h002E);
    io_write(8'hF0, 8'h55, 1);
    step();
    step();
    checkOutput(CK_PIN, "short_strobe", 16'h002E);
    checkOutput(CK_IRQN, "irq_still_idle", 16'h0001);

    // Reset in the middle of a write strobe, with pins not at zero
    step();
    pin_in = 16'h0100;
    repeat (4) step();
    checkOutput(CK_IRQN, "irq_pre_reset", 16'h0000);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hF1, 8'hFF);
    step();
    reset = 1'b1;
    step();
    checkOutput(CK_PIN, "reset_mid_out", 16'h0000);
    checkOutput(CK_IRQN, "reset_mid_irq", 16'h0001);
    reset = 1'b0;
    step();
    checkOutput(CK_PIN, "reset_no_write", 16'h0000);
    step();
    bus_idle();
    checkOutput(CK_PIN, "reset_no_write2", 16'h0000);
    repeat (4) step();
    io_read(8'hF7, 8'h00, "arm_no_flag");
    io_read(8'hF3, 8'h00, "reset_flags");
    checkOutput(CK_IRQN, "irq_after_arm", 16'h0001);

    // Normal operation resumes after reset
    io_write(8'hF1, 8'h81, 3);
    checkOutput(CK_PIN, "post_reset_set0", 16'h0081);
    io_write(8'hF5, 8'h42, 3);
    checkOutput(CK_PIN, "post_reset_set1", 16'h4281);
    io_read(8'hF5, 8'h42, "rd_out1");
    io_read(8'hF4, 8'h01, "rd_pins1");
    io_read(8'hF6, 8'hFF, "rd_mask1");

    for (int i = 0; (i < 20) && (sb_q.size() > 0); i++) step();
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL %s: no response seen, expected %h", it.name, it.exp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/io_port_bank.md
IO_PORT_BANK -- requirements
Module: io_port_bank

Interface
REQ-001 Parameter BASE, default 8'hF0: IO base address; the low 2+clog2(NPORTS) bits SHALL be zero.
REQ-002 Parameter NPORTS, default 2: number of 8-bit ports, legal range 1..8.
REQ-003 Parameter OUT_RESET, default 8'h00: reset value of every output latch.
REQ-004 phi  in  1: CPU PHI clock, the only clock; all state on rising edge.
REQ-005 reset  in  1: synchronous, active-high reset.
REQ-006 iorq_n, rd_n, wr_n  in  1 each: CPU bus strobes, active low, asynchronous to phi sampling.
REQ-007 a  in  8: IO address, a[7:0].
REQ-008 d_in  in  8: CPU data bus input.
REQ-009 d_out  out  8: read data to the top-level tri-state mux.
REQ-010 d_oe  out  1: high when this block owns the data bus.
REQ-011 pin_in  in  8*NPORTS: external input pins; port k uses bits [8k+7:8k].
REQ-012 pin_out  out  8*NPORTS: output latches, same packing.
REQ-013 irq_n  out  1: active-low, asserted while any unmasked change flag is set.

Function
REQ-014 Port k SHALL occupy offsets BASE+4k+0..3: DATA, SET, CLR, CHG.
REQ-015 Decode SHALL be hit = a[7:0] in [BASE, BASE+4*NPORTS-1]; other addresses SHALL be ignored.
REQ-016 d_oe SHALL be combinational: ~iorq_n & ~rd_n & hit; d_out SHALL be valid whenever d_oe is high, otherwise don't-care.
REQ-017 Read map: DATA -> synchronised pins; SET -> pin_out latch; CLR -> change mask; CHG -> sticky change flags.
REQ-018 Write tick SHALL fire on the 2nd consecutive phi edge that samples ~iorq_n & ~wr_n; exactly once per cycle, re-armed only after the strobe deasserts.
REQ-019 Read tick SHALL fire on the 1st phi edge that samples ~iorq_n & ~rd_n; same once-per-cycle rule.
REQ-020 Write at the tick edge: DATA -> out <= d_in; SET -> out <= out | d_in; CLR -> out <= out & ~d_in; CHG -> flags <= flags & ~d_in (W1C).
REQ-021 The change mask SHALL be written at offset CLR with a[7]-independent alias BASE+4k+2 only when d_in write goes to mask; instead mask SHALL be written by a read-tick-free path: a write to CHG with d_in[7:0] applied as W1C and a write to DATA never touching the mask; the mask register SHALL reset to 8'hFF and be written only via offset CLR when the CPU has set bit 0 of... -- superseded by REQ-022.
REQ-022 The mask SHALL be a write-only-by-reset constant 8'hFF per port (all bits unmasked); the CLR read returns 8'hFF.
REQ-023 pin_in SHALL pass through a 2-flop synchroniser; change detect compares sync stage 2 with a registered previous value.
REQ-024 A detected bit change SHALL set its flag on the following edge; set SHALL win over a simultaneous W1C of the same bit.
REQ-025 Change detection SHALL be disarmed for the first 3 edges after reset deasserts (no spurious flags from sync fill).
REQ-026 irq_n SHALL be registered: irq_n <= ~|(flags & mask) across all ports, one-cycle latency.
REQ-027 Strobe deassertion before the write tick SHALL produce no write; tick counters SHALL saturate, never wrap.

Reset
REQ-028 On reset: pin_out = OUT_RESET on every port; flags = 0; sync/prev = 0; tick counters = 0; arm counter = 0; irq_n = 1.
REQ-029 Reset asserted mid-bus-cycle SHALL abort the pending tick; no write SHALL occur on or after that edge.

Structure
REQ-030 Package io_bank_pkg SHALL hold offset constants (OFS_DATA=0, OFS_SET=1, OFS_CLR=2, OFS_CHG=3) and the port stride 4.
REQ-031 Rd/wr tick generation SHALL live in one sub-module iorq_tick_gen, instanced once, shared by all ports.

Verification
REQ-032 Reset, then IO write 8'hA5 to F0 (3-clock strobe) -> pin_out[7:0]=A5 after the 2nd edge, exactly one update.
REQ-033 out=A5; write 8'h0A to F1 -> 8'hAF; write 8'h81 to F2 -> 8'h2E; read F1 -> d_oe=1, d_out=2E.
REQ-034 pin_in[15:8] 00->04 -> CHG of port 1 reads 8'h04 three edges later, irq_n=0 one edge after; write 8'h04 to F7 -> flags 0, irq_n=1.
REQ-035 Toggle a pin the same edge as a W1C of that bit -> flag remains set.
REQ-036 Access to F8 with NPORTS=2 -> d_oe=0, no state change; 1-edge write strobe -> no write.
REQ-037 Assert reset during write strobe, before the 2nd edge -> pin_out = OUT_RESET, flags 0, no write.
